// File: rtl/l2_responder.sv
// l2_responder: single-port L2 backing-store model with fixed or LFSR-driven
// random access latency, for exercising cache/core request handshakes.
module l2_responder #(
  parameter int          WORD_W      = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RAND_RANGE  = 10,
  parameter int          RAND_EN     = 1,
  parameter int          FIXED_LAT   = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              l2_REN,
  input  logic              l2_WEN,
  input  logic [31:0]       l2_addr,
  input  logic [WORD_W-1:0] l2_store,
  output logic [WORD_W-1:0] l2_load,
  output logic [1:0]        l2_state
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Encoding doubles as the l2_state code: FREE, BUSY, ACCESS, ERROR.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               wr_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic [WORD_W-1:0]  load_q;

  logic [WORD_W-1:0]  mem [DEPTH_WORDS];

  logic               any_req;
  logic               one_req;
  logic               aligned;
  logic               in_range;
  logic [7:0]         rand_m1;
  logic [7:0]         cnt_init;
  logic               do_write;

  assign any_req  = l2_REN | l2_WEN;
  assign one_req  = l2_REN ^ l2_WEN;
  assign aligned  = (l2_addr[1:0] == 2'b00);
  assign in_range = ({2'b00, l2_addr[31:2]} < 32'(DEPTH_WORDS));

  // Counter preload is latency-1 so that BUSY is visible for exactly lat cycles.
  assign rand_m1  = 8'(lfsr_q % 16'(RAND_RANGE));
  assign cnt_init = (RAND_EN != 0) ? rand_m1 : 8'(FIXED_LAT - 1);

  // Galois right-shift form of x^16+x^14+x^13+x^11+1.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // A write commits only on the edge that enters ACCESS, and never under reset.
  assign do_write = !RST && (state_q == WAIT) && (cnt_q == 8'd0) && any_req && wr_q;

  // Request FSM, latency counter, LFSR and read-data register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      lfsr_q  <= LFSR_SEED;
      load_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            if (one_req && aligned && in_range) begin
              idx_q   <= l2_addr[IDX_W+1:2];
              wdata_q <= l2_store;
              wr_q    <= l2_WEN;
              cnt_q   <= cnt_init;
              state_q <= WAIT;
            end else begin
              state_q <= ERR;
            end
          end
        end
        WAIT: begin
          if (!any_req) begin
            state_q <= IDLE;
          end else if (cnt_q == 8'd0) begin
            state_q <= ACCESS;
            if (!wr_q) load_q <= mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ACCESS:  state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Backing store; deliberately not reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (do_write) mem[idx_q] <= wdata_q;
  end

  assign l2_load  = load_q;
  assign l2_state = state_q;

endmodule

// File: tb/tb_l2_responder.sv
// tb_l2_responder: drives a fixed-latency and a random-latency instance from
// shared inputs, checking each against a word-array model and the LFSR rule.
module tb_l2_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REN = 1'b0;
  logic        WEN = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store = '0;
  logic [31:0] ld_f, ld_r;
  logic [1:0]  st_f, st_r;

  always #5 CLK = ~CLK;

  l2_responder #(.RAND_EN(0), .FIXED_LAT(2)) dut_f (
    .CLK(CLK), .RST(RST), .l2_REN(REN), .l2_WEN(WEN), .l2_addr(addr),
    .l2_store(store), .l2_load(ld_f), .l2_state(st_f));

  l2_responder #(.RAND_EN(1), .RAND_RANGE(10), .LFSR_SEED(16'hACE1)) dut_r (
    .CLK(CLK), .RST(RST), .l2_REN(REN), .l2_WEN(WEN), .l2_addr(addr),
    .l2_store(store), .l2_load(ld_r), .l2_state(st_r));

  int          nvec = 0;
  int          nerr = 0;
  bit          sel  = 1'b0;
  logic [31:0] mem_f [int];
  logic [31:0] mem_r [int];
  logic [31:0] exp_ld_f = '0;
  logic [15:0] m_lfsr;
  int          hist [11];

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, one step per clock.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ ((16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10));
    return n;
  endfunction

  always @(posedge CLK) begin
    if (RST) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [1:0] st();
    return sel ? st_r : st_f;
  endfunction

  function automatic logic [31:0] ld();
    return sel ? ld_r : ld_f;
  endfunction

  // Issue one request and hold it until ACCESS; report BUSY count and load.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int busy, output logic [31:0] ld_acc,
                         output logic [1:0] post, output bit bad);
    bit done;
    busy = 0; bad = 1'b0; done = 1'b0;
    REN = !wr; WEN = wr; addr = a; store = d;
    for (int i = 0; i < 300 && !done && !bad; i++) begin
      @(negedge CLK);
      if (st() == 2'd2)      done = 1'b1;
      else if (st() == 2'd1) busy++;
      else                   bad = 1'b1;
    end
    if (!done) bad = 1'b1;
    ld_acc = ld();
    REN = 1'b0; WEN = 1'b0;
    @(negedge CLK);
    post = st();
  endtask

  task automatic test_reset();
    RST = 1'b1; REN = 1'b0; WEN = 1'b0;
    repeat (3) @(negedge CLK);
    nvec++; if (st_f !== 2'd0) begin nerr++; $display("FAIL reset_state_f: got %0d want 0", st_f); end
    nvec++; if (ld_f !== 32'd0) begin nerr++; $display("FAIL reset_load_f: got %0h want 0", ld_f); end
    nvec++; if (st_r !== 2'd0) begin nerr++; $display("FAIL reset_state_r: got %0d want 0", st_r); end
    nvec++; if (ld_r !== 32'd0) begin nerr++; $display("FAIL reset_load_r: got %0h want 0", ld_r); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_fixed_basic();
    int b; logic [31:0] l; logic [1:0] p; bit bad;
    sel = 1'b0;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, b, l, p, bad);
    mem_f[4] = 32'hDEADBEEF;
    nvec++; if (bad || b != 2) begin nerr++; $display("FAIL wr_busy: got %0d bad=%0d want 2", b, bad); end
    nvec++; if (p !== 2'd0) begin nerr++; $display("FAIL wr_post: got %0d want 0", p); end
    nvec++; if (l !== exp_ld_f) begin nerr++; $display("FAIL wr_load_kept: got %0h want %0h", l, exp_ld_f); end
    run_txn(1'b1, 32'h0, 32'hA5A50000, b, l, p, bad);
    mem_f[0] = 32'hA5A50000;
    run_txn(1'b0, 32'h10, 32'h0, b, l, p, bad);
    exp_ld_f = 32'hDEADBEEF;
    nvec++; if (bad || b != 2) begin nerr++; $display("FAIL rd_busy: got %0d bad=%0d want 2", b, bad); end
    nvec++; if (l !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data: got %0h want deadbeef", l); end
  endtask

  task automatic test_fixed_random();
    int b; logic [31:0] l, d, want; logic [1:0] p; bit bad, wr; int idx;
    sel = 1'b0;
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(31, 0));
      wr  = ($urandom_range(1, 0) == 1) || !mem_f.exists(idx);
      d   = $urandom;
      run_txn(wr, 32'(idx * 4), d, b, l, p, bad);
      if (wr) begin
        mem_f[idx] = d;
        want = exp_ld_f;
      end else begin
        want = mem_f[idx];
        exp_ld_f = want;
      end
      nvec++;
      if (bad || b != 2 || p !== 2'd0 || l !== want) begin
        nerr++;
        $display("FAIL fixed_rand[%0d]: busy=%0d post=%0d load=%0h want busy=2 post=0 load=%0h", n, b, p, l, want);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [4];
    bit          er [4];
    bit          ew [4];
    int b; logic [31:0] l; logic [1:0] p; bit bad;
    sel = 1'b0;
    ea[0] = 32'h0;    er[0] = 1; ew[0] = 1;
    ea[1] = 32'h4002; er[1] = 1; ew[1] = 0;
    ea[2] = 32'h4000; er[2] = 1; ew[2] = 0;
    ea[3] = 32'h0001; er[3] = 0; ew[3] = 1;
    for (int k = 0; k < 4; k++) begin
      REN = er[k]; WEN = ew[k]; addr = ea[k]; store = 32'hBAD0BAD0;
      @(negedge CLK);
      nvec++; if (st_f !== 2'd3) begin nerr++; $display("FAIL err_state[%0d]: got %0d want 3", k, st_f); end
      REN = 1'b0; WEN = 1'b0;
      @(negedge CLK);
      nvec++; if (st_f !== 2'd0) begin nerr++; $display("FAIL err_free[%0d]: got %0d want 0", k, st_f); end
      nvec++; if (ld_f !== exp_ld_f) begin nerr++; $display("FAIL err_load[%0d]: got %0h want %0h", k, ld_f, exp_ld_f); end
    end
    run_txn(1'b0, 32'h0, 32'h0, b, l, p, bad);
    exp_ld_f = mem_f[0];
    nvec++; if (bad || l !== mem_f[0]) begin nerr++; $display("FAIL err_mem0: got %0h want %0h", l, mem_f[0]); end
  endtask

  task automatic test_abort();
    int b; logic [31:0] l; logic [1:0] p; bit bad;
    sel = 1'b0;
    run_txn(1'b1, 32'h20, 32'h5555AAAA, b, l, p, bad);
    mem_f[8] = 32'h5555AAAA;
    REN = 1'b0; WEN = 1'b1; addr = 32'h20; store = 32'h1234;
    @(negedge CLK);
    nvec++; if (st_f !== 2'd1) begin nerr++; $display("FAIL abort_busy: got %0d want 1", st_f); end
    WEN = 1'b0;
    @(negedge CLK);
    nvec++; if (st_f !== 2'd0) begin nerr++; $display("FAIL abort_free: got %0d want 0", st_f); end
    nvec++; if (ld_f !== exp_ld_f) begin nerr++; $display("FAIL abort_load: got %0h want %0h", ld_f, exp_ld_f); end
    run_txn(1'b0, 32'h20, 32'h0, b, l, p, bad);
    exp_ld_f = 32'h5555AAAA;
    nvec++; if (bad || l !== 32'h5555AAAA) begin nerr++; $display("FAIL abort_mem: got %0h want 5555aaaa", l); end
  endtask

  task automatic test_latch();
    int b; logic [31:0] l; logic [1:0] p; bit bad, done;
    sel = 1'b0;
    run_txn(1'b1, 32'h44, 32'h44444444, b, l, p, bad);
    mem_f[17] = 32'h44444444;
    REN = 1'b0; WEN = 1'b1; addr = 32'h40; store = 32'h40404040;
    @(negedge CLK);
    addr = 32'h44; store = 32'hFFFF0000;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (st_f == 2'd2) done = 1'b1;
    end
    nvec++; if (!done) begin nerr++; $display("FAIL latch_access: got timeout want ACCESS"); end
    WEN = 1'b0;
    @(negedge CLK);
    mem_f[16] = 32'h40404040;
    run_txn(1'b0, 32'h40, 32'h0, b, l, p, bad);
    nvec++; if (l !== 32'h40404040) begin nerr++; $display("FAIL latch_addr40: got %0h want 40404040", l); end
    run_txn(1'b0, 32'h44, 32'h0, b, l, p, bad);
    exp_ld_f = 32'h44444444;
    nvec++; if (l !== 32'h44444444) begin nerr++; $display("FAIL latch_addr44: got %0h want 44444444", l); end
  endtask

  task automatic test_reset_wait();
    int b; logic [31:0] l; logic [1:0] p; bit bad;
    sel = 1'b0;
    run_txn(1'b1, 32'h30, 32'h30303030, b, l, p, bad);
    mem_f[12] = 32'h30303030;
    REN = 1'b0; WEN = 1'b1; addr = 32'h30; store = 32'hCAFEF00D;
    @(negedge CLK);
    nvec++; if (st_f !== 2'd1) begin nerr++; $display("FAIL rstw_busy: got %0d want 1", st_f); end
    RST = 1'b1; WEN = 1'b0;
    @(negedge CLK);
    nvec++; if (st_f !== 2'd0) begin nerr++; $display("FAIL rstw_state: got %0d want 0", st_f); end
    nvec++; if (ld_f !== 32'd0) begin nerr++; $display("FAIL rstw_load: got %0h want 0", ld_f); end
    RST = 1'b0;
    exp_ld_f = '0;
    @(negedge CLK);
    run_txn(1'b0, 32'h30, 32'h0, b, l, p, bad);
    exp_ld_f = 32'h30303030;
    nvec++; if (l !== 32'h30303030) begin nerr++; $display("FAIL rstw_mem: got %0h want 30303030", l); end
  endtask

  // 0xACE1 mod 10 = 7, so the first request after reset waits 8 cycles.
  task automatic test_seed_latency();
    int b; logic [31:0] l; logic [1:0] p; bit bad;
    sel = 1'b1;
    RST = 1'b1; REN = 1'b0; WEN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    run_txn(1'b0, 32'h200, 32'h0, b, l, p, bad);
    nvec++; if (bad || b != 8) begin nerr++; $display("FAIL seed_latency: got %0d bad=%0d want 8", b, bad); end
    nvec++; if (p !== 2'd0) begin nerr++; $display("FAIL seed_post: got %0d want 0", p); end
  endtask

  task automatic test_back_to_back();
    int b, want_b, idx; logic [31:0] l, d; logic [1:0] p; bit bad;
    sel = 1'b1;
    for (int k = 0; k < 11; k++) hist[k] = 0;
    for (int i = 64; i < 96; i++) begin
      d = $urandom;
      want_b = int'(m_lfsr % 16'd10) + 1;
      run_txn(1'b1, 32'(i * 4), d, b, l, p, bad);
      mem_r[i] = d;
      nvec++;
      if (bad || b != want_b || p !== 2'd0) begin
        nerr++; $display("FAIL rand_wr[%0d]: busy=%0d post=%0d want busy=%0d post=0", i, b, p, want_b);
      end
    end
    for (int n = 0; n < 1000; n++) begin
      idx = int'($urandom_range(95, 64));
      want_b = int'(m_lfsr % 16'd10) + 1;
      run_txn(1'b0, 32'(idx * 4), 32'h0, b, l, p, bad);
      if (b >= 1 && b <= 10) hist[b]++;
      nvec++;
      if (bad || b != want_b || l !== mem_r[idx]) begin
        nerr++; $display("FAIL rand_rd[%0d]: busy=%0d load=%0h want busy=%0d load=%0h", n, b, l, want_b, mem_r[idx]);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      nvec++; if (hist[k] == 0) begin nerr++; $display("FAIL hist[%0d]: got 0 runs want >0", k); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_basic();
    test_fixed_random();
    test_errors();
    test_abort();
    test_latch();
    test_reset_wait();
    test_seed_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
